mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing one single-port unified memory between the instruction-fetch port and the load/store port of the multicycle rv32i core. It sequences each access through a fixed-latency memory protocol and returns one registered acknowledge per transaction. It sits between the core's fetch and data interfaces and the memory macro, and enables a single program/data image at pc_init_i = 32'h1000.

## Interface
- MEM_LATENCY, 1: cycles from the mem_req_o cycle to valid mem_rdata_i; legal range 1..4
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  fetch request, level, held until if_ack_o
- if_addr_i  in  32  fetch byte address (word_st)
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  32  fetched word, valid only while if_ack_o=1
- d_req_i  in  1  data request, level, held until d_ack_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  store data
- d_be_i  in  4  store byte enables
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  32  load word; 0 for stores; valid only while d_ack_o=1
- mem_req_o  out  1  memory strobe, exactly one cycle per transaction
- mem_we_o, mem_addr_o (32), mem_wdata_o (32), mem_be_o (4)  out  memory command, valid only while mem_req_o=1, else 0
- mem_rdata_i  in  32  memory read data, valid MEM_LATENCY cycles after mem_req_o

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if no request, stay. Otherwise latch grantee, command fields and owner; go to ISSUE.
- Arbitration when both requests are high in IDLE: grant the port not granted last (round-robin via last_grant). A single request is always granted. last_grant updates on every grant.
- ISSUE: mem_req_o=1 with the latched command; load counter with MEM_LATENCY-1; go to WAIT.
- WAIT: decrement counter; when counter=0, capture mem_rdata_i into the response register; go to RESP.
- RESP: assert ack of the owner with the captured data (stores return 0); go to IDLE.
- Fetch is read-only: mem_we_o=0, mem_be_o=4'b1111.
- Addresses pass through unmodified; alignment is the core's responsibility.
- Requester must drop or replace its request in the cycle after its ack. IDLE re-samples the requests in that cycle, so back-to-back requests incur no idle cycle.
- Command inputs are latched in IDLE. Changes during a transaction are ignored.

## Timing
- Reset: state=IDLE, last_grant=IF (so the first tie goes to data), counter=0, all outputs 0. Reset has priority over every transition.
- Reset mid-transaction aborts the transaction. Outputs are 0 from the cycle after the reset edge, and the aborted request never acks.
- Request seen in IDLE at cycle 0:
  - mem_req_o in cycle 1
  - mem_rdata_i sampled in cycle 1+MEM_LATENCY
  - ack in cycle MEM_LATENCY+2
- Throughput: one transaction per MEM_LATENCY+3 cycles. With continuous contention, grants strictly alternate.
- At most one of if_ack_o / d_ack_o is high in any cycle. mem_req_o is never high in two consecutive cycles.

## Test plan
- Single fetch, MEM_LATENCY=1, if_addr_i=32'h1000, memory returns 32'h00500093:
  - mem_req_o in cycle 1 with addr 32'h1000, we=0, be=4'hF
  - if_ack_o in cycle 3 with if_rdata_o=32'h00500093
  - d_ack_o stays 0
- Store: d_we_i=1, d_addr_i=32'h2004, d_wdata_i=32'hDEADBEEF, d_be_i=4'b0011:
  - memory command carries exactly these values
  - d_ack_o in cycle 3 with d_rdata_o=0
- Simultaneous if_req_i and d_req_i right after reset, both held for 3 transactions each:
  - grant order data, IF, data, IF, data, IF
  - acks every 4 cycles, never both high
- MEM_LATENCY=4, load from 32'h3000 returning 32'h12345678:
  - mem_req_o in cycle 1
  - d_ack_o in cycle 6 with 32'h12345678
- rst_i asserted in the WAIT cycle of a fetch:
  - no if_ack_o
  - all outputs 0 next cycle
  - a new fetch issued after reset release completes normally with ack at cycle 3
- Back-to-back fetches, req held high after ack with the next address:
  - second mem_req_o occurs exactly 4 cycles after the first
  - no idle gap

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the fetch and load/store ports; one transaction in flight, one registered ack each.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1  // legal range 1..4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_be_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic OwnIf = 1'b0;
    localparam logic OwnD  = 1'b1;
    localparam logic [1:0] CntLoad = 2'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        grant_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        grant_d      = OwnIf;

        unique case (state_q)
            StIdle: begin
                if (if_req_i || d_req_i) begin
                    // On a tie, the port that did not win last time goes first.
                    grant_d      = d_req_i && (!if_req_i || (last_grant_q == OwnIf));
                    owner_d      = grant_d;
                    last_grant_d = grant_d;
                    if (grant_d == OwnD) begin
                        we_d    = d_we_i;
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                        be_d    = d_be_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr_i;
                        wdata_d = 32'h0;
                        be_d    = 4'b1111;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = we_q ? 32'h0 : mem_rdata_i;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= OwnIf;
            owner_q      <= OwnIf;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            cnt_q        <= 2'd0;
            rdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode only registered state, so they drop to 0 right after reset.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        mem_be_o    = 4'h0;
        if_ack_o    = 1'b0;
        if_rdata_o  = 32'h0;
        d_ack_o     = 1'b0;
        d_rdata_o   = 32'h0;

        if (state_q == StIssue) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            mem_be_o    = be_q;
        end

        if (state_q == StResp) begin
            if (owner_q == OwnD) begin
                d_ack_o   = 1'b1;
                d_rdata_o = rdata_q;
            end else begin
                if_ack_o   = 1'b1;
                if_rdata_o = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at latency 1, one at latency 4,
// each backed by a memory model that drives valid data only in the sampling cycle.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Latency-1 instance signals
    logic        a_if_req, a_d_req, a_d_we;
    logic [31:0] a_if_addr, a_d_addr, a_d_wdata;
    logic [3:0]  a_d_be;
    logic        a_if_ack, a_d_ack, a_mem_req, a_mem_we;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_be;

    // Latency-4 instance signals
    logic        b_if_req, b_d_req, b_d_we;
    logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
    logic [3:0]  b_d_be;
    logic        b_if_ack, b_d_ack, b_mem_req, b_mem_we;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_be;

    mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_ack_o(a_if_ack), .if_rdata_o(a_if_rdata),
        .d_req_i(a_d_req), .d_we_i(a_d_we), .d_addr_i(a_d_addr), .d_wdata_i(a_d_wdata),
        .d_be_i(a_d_be), .d_ack_o(a_d_ack), .d_rdata_o(a_d_rdata),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_rdata_i(a_mem_rdata)
    );

    mem_arbiter #(.MEM_LATENCY(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack), .if_rdata_o(b_if_rdata),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_be_i(b_d_be), .d_ack_o(b_d_ack), .d_rdata_o(b_d_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_1000: mem_word = 32'h0050_0093;
            32'h0000_1004: mem_word = 32'hA0A0_0001;
            32'h0000_3000: mem_word = 32'h1234_5678;
            default:       mem_word = addr ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Memory models: data is valid only in the cycle MEM_LATENCY after the strobe.
    logic        a_v_q = 1'b0;
    logic [31:0] a_addr_q = 32'h0;
    always @(posedge clk) begin
        a_v_q    <= a_mem_req;
        a_addr_q <= a_mem_addr;
    end
    assign a_mem_rdata = a_v_q ? mem_word(a_addr_q) : 32'hBAD0_BAD0;

    logic [3:0]  b_v_q = 4'h0;
    logic [31:0] b_addr_q [4];
    always @(posedge clk) begin
        b_v_q       <= {b_v_q[2:0], b_mem_req};
        b_addr_q[0] <= b_mem_addr;
        b_addr_q[1] <= b_addr_q[0];
        b_addr_q[2] <= b_addr_q[1];
        b_addr_q[3] <= b_addr_q[2];
    end
    assign b_mem_rdata = b_v_q[3] ? mem_word(b_addr_q[3]) : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic quiet_a(input string tag);
        chk1({tag, ".mem_req"}, a_mem_req, 1'b0);
        chk1({tag, ".if_ack"}, a_if_ack, 1'b0);
        chk1({tag, ".d_ack"}, a_d_ack, 1'b0);
        chk({tag, ".mem_addr"}, a_mem_addr, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_we = 0;
        a_d_addr = 0; a_d_wdata = 0; a_d_be = 0;
        b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0;
        b_d_addr = 0; b_d_wdata = 0; b_d_be = 0;
        tick();
        do_reset();
        quiet_a("reset");
        chk1("reset.b_mem_req", b_mem_req, 1'b0);
        chk1("reset.b_d_ack", b_d_ack, 1'b0);

        // Latency 4 load from 0x3000
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h3000; b_d_be = 4'hF;
        chk1("lat4.c0.mem_req", b_mem_req, 1'b0);
        tick();
        chk1("lat4.c1.mem_req", b_mem_req, 1'b1);
        chk("lat4.c1.addr", b_mem_addr, 32'h3000);
        chk1("lat4.c1.we", b_mem_we, 1'b0);
        chk("lat4.c1.be", {28'h0, b_mem_be}, 32'hF);
        chk("lat4.c1.wdata", b_mem_wdata, 32'h0);
        tick();
        chk1("lat4.c2.mem_req", b_mem_req, 1'b0);
        tick(); tick(); tick();
        chk1("lat4.c5.d_ack", b_d_ack, 1'b0);
        tick();
        chk1("lat4.c6.d_ack", b_d_ack, 1'b1);
        chk("lat4.c6.rdata", b_d_rdata, 32'h1234_5678);
        chk1("lat4.c6.if_ack", b_if_ack, 1'b0);
        chk("lat4.c6.if_rdata", b_if_rdata, 32'h0);
        tick();
        b_d_req = 0;
        chk1("lat4.c7.d_ack", b_d_ack, 1'b0);

        // Single fetch, latency 1
        a_if_req = 1; a_if_addr = 32'h1000;
        chk1("fetch.c0.mem_req", a_mem_req, 1'b0);
        tick();
        chk1("fetch.c1.mem_req", a_mem_req, 1'b1);
        chk("fetch.c1.addr", a_mem_addr, 32'h1000);
        chk1("fetch.c1.we", a_mem_we, 1'b0);
        chk("fetch.c1.be", {28'h0, a_mem_be}, 32'hF);
        tick();
        quiet_a("fetch.c2");
        tick();
        chk1("fetch.c3.if_ack", a_if_ack, 1'b1);
        chk("fetch.c3.rdata", a_if_rdata, 32'h0050_0093);
        chk1("fetch.c3.d_ack", a_d_ack, 1'b0);
        tick();
        a_if_req = 0;
        quiet_a("fetch.c4");
        tick();
        quiet_a("fetch.c5");

        // Store; inputs are scrambled after issue to show they were latched
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h2004; a_d_wdata = 32'hDEAD_BEEF; a_d_be = 4'b0011;
        tick();
        a_d_addr = 32'hFFFF_FFFC; a_d_wdata = 32'h0; a_d_be = 4'hF;
        chk1("store.c1.mem_req", a_mem_req, 1'b1);
        chk1("store.c1.we", a_mem_we, 1'b1);
        chk("store.c1.addr", a_mem_addr, 32'h2004);
        chk("store.c1.wdata", a_mem_wdata, 32'hDEAD_BEEF);
        chk("store.c1.be", {28'h0, a_mem_be}, 32'h3);
        tick();
        tick();
        chk1("store.c3.d_ack", a_d_ack, 1'b1);
        chk("store.c3.rdata", a_d_rdata, 32'h0);
        chk1("store.c3.if_ack", a_if_ack, 1'b0);
        tick();
        a_d_req = 0; a_d_we = 0; a_d_addr = 32'h3000; a_d_be = 4'hF;

        // Back-to-back fetches with no idle gap
        a_if_req = 1; a_if_addr = 32'h1000;
        tick();
        chk1("b2b.c1.mem_req", a_mem_req, 1'b1);
        chk("b2b.c1.addr", a_mem_addr, 32'h1000);
        tick(); tick();
        chk("b2b.c3.rdata", a_if_rdata, 32'h0050_0093);
        tick();
        a_if_addr = 32'h1004;
        chk1("b2b.c4.mem_req", a_mem_req, 1'b0);
        tick();
        chk1("b2b.c5.mem_req", a_mem_req, 1'b1);
        chk("b2b.c5.addr", a_mem_addr, 32'h1004);
        tick(); tick();
        chk1("b2b.c7.if_ack", a_if_ack, 1'b1);
        chk("b2b.c7.rdata", a_if_rdata, 32'hA0A0_0001);
        tick();
        a_if_req = 0;

        // Contention right after reset: data, IF, data, IF, data, IF
        do_reset();
        a_if_req = 1; a_if_addr = 32'h1000; a_d_req = 1; a_d_addr = 32'h3000;
        for (int t = 0; t < 6; t++) begin
            automatic logic exp_d = ((t % 2) == 0);
            chk1($sformatf("arb%0d.idle.mem_req", t), a_mem_req, 1'b0);
            tick();
            chk1($sformatf("arb%0d.mem_req", t), a_mem_req, 1'b1);
            chk($sformatf("arb%0d.addr", t), a_mem_addr, exp_d ? 32'h3000 : 32'h1000);
            tick();
            chk1($sformatf("arb%0d.c2.if_ack", t), a_if_ack, 1'b0);
            chk1($sformatf("arb%0d.c2.d_ack", t), a_d_ack, 1'b0);
            tick();
            chk1($sformatf("arb%0d.d_ack", t), a_d_ack, exp_d);
            chk1($sformatf("arb%0d.if_ack", t), a_if_ack, !exp_d);
            chk($sformatf("arb%0d.rdata", t), exp_d ? a_d_rdata : a_if_rdata,
                exp_d ? 32'h1234_5678 : 32'h0050_0093);
            tick();
            if (t == 4) a_d_req = 0;
            if (t == 5) a_if_req = 0;
        end

        // Reset during WAIT of a fetch aborts it
        a_if_req = 1; a_if_addr = 32'h1000;
        tick();
        chk1("abort.c1.mem_req", a_mem_req, 1'b1);
        tick();
        rst = 1; a_if_req = 0;
        tick();
        rst = 0;
        quiet_a("abort.c3");
        chk("abort.c3.if_rdata", a_if_rdata, 32'h0);
        tick();
        quiet_a("abort.c4");
        a_if_req = 1; a_if_addr = 32'h1004;
        tick();
        chk1("post.c1.mem_req", a_mem_req, 1'b1);
        chk("post.c1.addr", a_mem_addr, 32'h1004);
        tick(); tick();
        chk1("post.c3.if_ack", a_if_ack, 1'b1);
        chk("post.c3.rdata", a_if_rdata, 32'hA0A0_0001);
        tick();
        a_if_req = 0;
        tick();
        quiet_a("post.c5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
